truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Stimulus-and-capture stage placed directly upstream of a 3-input combinational truth-table gate module. On request it drives in1/in2/in3 through all eight combinations in ascending order, holds each for a programmable settle time, samples the gate's single output, and assembles the observed 8-bit truth table. It compares the result against an expected hex code and reports pass/fail with a per-row mismatch mask.

## Interface
- SETTLE_CYCLES, 4: cycles each input vector is held before and including its sample cycle; legal range 1 to 255.
- EXPECTED, 8'hAB: expected truth-table code in the same bit order as table_out.

One clock; reset is synchronous and active-high.
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  sweep request; sampled only in IDLE
- dut_out  input  1  output of the gate under test
- in1, in2, in3  output  1 each  gate inputs; {in1,in2,in3} = current row index
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when results become valid
- table_out  output  8  observed table; bit (7-i) = dut_out for row i
- mismatch  output  8  table_out XOR EXPECTED
- pass  output  1  mismatch == 0; meaningful from done onward

## Operation
- States: IDLE, APPLY, DONE.
- IDLE: inputs = 000, busy = 0. start = 1 -> APPLY with row = 0 and settle count = 0; table register cleared.
- APPLY: busy = 1; {in1,in2,in3} driven from the registered row index. Settle count increments each cycle. On the last hold cycle, dut_out is written into table bit (7-row). If row = 7, go to DONE; otherwise increment row and clear the count.
- DONE: one cycle. done = 1, busy = 0, inputs return to 000, then go to IDLE.
- table_out, mismatch and pass update only on entry to DONE. They hold until the next accepted start, which clears them to 0, 8'h00 and 0.
- start while in APPLY or DONE is ignored; there is no queuing.
- Row index is 3 bits and never wraps mid-sweep. Settle counter width is 8 bits.
- Reset values: in1..in3 = 0, busy = 0, done = 0, table_out = 0, mismatch = 0, pass = 0, state = IDLE.
- rst mid-sweep abandons the sweep immediately. The partial table is discarded and all outputs take their reset values on the next edge.

## Timing
- start sampled high in IDLE at edge T: row 0 is driven from T+1.
- Each row is held for H cycles. H = SETTLE_CYCLES, or SETTLE_CYCLES+2 with the synchronizer enabled.
- Sample of row i occurs at cycle T+(i+1)·H.
- done pulses at cycle T+8·H+1; state is IDLE at T+8·H+2.
- Minimum start-to-start period: 8·H+2 cycles. With S=4 and no sync this is 34.
- dut_out may glitch freely; only its value on the sample cycle matters.

## Configuration
- TT_SYNC_EN defined: dut_out passes through a two-flop synchronizer before sampling, and the hold per row is extended by 2 cycles, so H = SETTLE_CYCLES+2. All reported results are otherwise identical.
- TT_SYNC_EN undefined: dut_out is sampled directly and H = SETTLE_CYCLES.

## Structure
- Package tt_sweep_pkg contains:
  - the state enum (IDLE, APPLY, DONE)
  - NUM_ROWS = 8
  - ROW_W = 3
  - TABLE_W = 8
  - SYNC_STAGES = 2
- Sub-module tt_sync2 is the two-flop synchronizer, instantiated only under TT_SYNC_EN.

## Test plan
All scenarios use SETTLE_CYCLES=4, EXPECTED=8'hAB, TT_SYNC_EN undefined, and a behavioural 0xAB gate model unless stated.
- Reset, then start pulse at T -> done at T+33; table_out=8'hAB, mismatch=8'h00, pass=1; inputs step 000..111 every 4 cycles.
- dut_out tied 0 -> table_out=8'h00, mismatch=8'hAB, pass=0.
- Extra start pulses at T+5 and T+20 -> ignored; exactly one done, at T+33.
- rst asserted while row=3 -> next cycle busy=0, inputs=000, table_out=0; a fresh start then completes with pass=1.
- start held high continuously -> done pulses at T+33, T+67, T+101; each sweep reports 8'hAB.
- dut_out toggles every cycle except the sample cycles, where it is correct -> table_out=8'hAB. Rebuild with TT_SYNC_EN -> done at T+49, table_out=8'hAB.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } tt_state_e;

    localparam int unsigned NUM_ROWS    = 8;
    localparam int unsigned ROW_W       = 3;
    localparam int unsigned TABLE_W     = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for the gate output; used only when TT_SYNC_EN is defined.
module tt_sync2
    import tt_sweep_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all eight rows, captures its truth table and compares it
// against EXPECTED. Optional macro TT_SYNC_EN adds a two-flop synchronizer on dut_out.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int unsigned           SETTLE_CYCLES = 4,
    parameter logic [TABLE_W-1:0]    EXPECTED      = 8'hAB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dut_out,
    output logic               in1,
    output logic               in2,
    output logic               in3,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] table_out,
    output logic [TABLE_W-1:0] mismatch,
    output logic               pass
);

    logic sample_bit;

`ifdef TT_SYNC_EN
    // One extra counter bit so SETTLE_CYCLES=255 plus the synchronizer delay still fits.
    localparam int unsigned HOLD = SETTLE_CYCLES + SYNC_STAGES;
    localparam int unsigned CW   = CNT_W + 1;

    tt_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (dut_out),
        .q_o (sample_bit)
    );
`else
    localparam int unsigned HOLD = SETTLE_CYCLES;
    localparam int unsigned CW   = CNT_W;

    assign sample_bit = dut_out;
`endif

    localparam logic [CW-1:0]    LAST_CNT = CW'(HOLD - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    tt_state_e          state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TABLE_W-1:0] acc_q, acc_d;
    logic [TABLE_W-1:0] table_q, table_d;
    logic [TABLE_W-1:0] mismatch_q, mismatch_d;
    logic               pass_q, pass_d;
    logic [ROW_W-1:0]   bit_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            table_q    <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            table_q    <= table_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        table_d    = table_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        bit_idx    = LAST_ROW - row_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = APPLY;
                    row_d      = '0;
                    cnt_d      = '0;
                    acc_d      = '0;
                    table_d    = '0;
                    mismatch_d = '0;
                    pass_d     = 1'b0;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Row i lands in bit (7-i) so row 0 is the MSB of the reported code.
                    acc_d[bit_idx] = sample_bit;
                    cnt_d          = '0;
                    if (row_q == LAST_ROW) begin
                        state_d    = DONE;
                        table_d    = acc_d;
                        mismatch_d = acc_d ^ EXPECTED;
                        pass_d     = (acc_d == EXPECTED);
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy            = (state_q == APPLY);
    assign done            = (state_q == DONE);
    assign {in1, in2, in3} = busy ? row_q : '0;
    assign table_out       = table_q;
    assign mismatch        = mismatch_q;
    assign pass            = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper with a behavioural 0xAB gate model.
module tb_truth_table_sweeper;

    localparam int S    = 4;
`ifdef TT_SYNC_EN
    localparam int H    = S + 2;
    localparam int LAT  = 3;
`else
    localparam int H    = S;
    localparam int LAT  = 1;
`endif
    localparam int PERIOD = 8 * H + 2;

    typedef struct {
        logic [7:0] tbl;
        int         done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, dut_out;
    logic       in1, in2, in3, busy, done, pass;
    logic [7:0] table_out, mismatch;

    logic [7:0] exp_code = 8'hAB;
    int         cyc = 0;
    int         nchk = 0;
    int         nfail = 0;
    int         mode = 0;          // 0 good gate, 1 tied low, 2 glitching
    int         sw_T = 0;
    bit         sw_active = 1'b0;
    exp_t       sb[$];

    truth_table_sweeper #(
        .SETTLE_CYCLES (S),
        .EXPECTED      (8'hAB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_out   (dut_out),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .mismatch  (mismatch),
        .pass      (pass)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        logic [2:0] r;
        logic       good;
        r    = {in1, in2, in3};
        good = exp_code[3'd7 - r];
        case (mode)
            1:       dut_out = 1'b0;
            2:       dut_out = (((cyc - sw_T + LAT) % H) == 0) ? good : cyc[0];
            default: dut_out = good;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Scoreboard and input-stepping monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cyc", cyc, e.done_cyc);
                chk("table_out", {24'd0, table_out}, {24'd0, e.tbl});
                chk("mismatch", {24'd0, mismatch}, {24'd0, e.tbl ^ 8'hAB});
                chk("pass", {31'd0, pass}, {31'd0, e.tbl == 8'hAB});
            end
        end
        if (sw_active) begin
            if (cyc < sw_T + 8 * H) begin
                chk("busy_sweep", {31'd0, busy}, 32'd1);
                chk("row_inputs", {29'd0, in1, in2, in3}, (cyc - sw_T) / H);
            end else begin
                chk("busy_done", {31'd0, busy}, 32'd0);
                chk("inputs_done", {29'd0, in1, in2, in3}, 32'd0);
                sw_active = 1'b0;
            end
        end
    end

    task automatic start_sweep(input logic [7:0] tbl, output int t);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b0;
        e.tbl      = tbl;
        e.done_cyc = t + 8 * H;
        sb.push_back(e);
        sw_T      = t;
        sw_active = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_inputs", {29'd0, in1, in2, in3}, 32'd0);
        chk("rst_table", {24'd0, table_out}, 32'd0);
        chk("rst_mismatch", {24'd0, mismatch}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good gate
        mode = 0;
        start_sweep(8'hAB, t);
        wait_idle();
        chk("held_table", {24'd0, table_out}, 32'hAB);
        chk("held_pass", {31'd0, pass}, 32'd1);

        // Gate output stuck low
        mode = 1;
        start_sweep(8'h00, t);
        wait_idle();
        mode = 0;

        // Extra start pulses during a sweep are ignored
        start_sweep(8'hAB, t);
        while (cyc < t + 4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 19) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset while row 3 is applied
        start_sweep(8'hAB, t);
        while (cyc < t + 3 * H + 1) @(negedge clk);
        rst       = 1'b1;
        sw_active = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_inputs", {29'd0, in1, in2, in3}, 32'd0);
        chk("midrst_table", {24'd0, table_out}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start_sweep(8'hAB, t);
        wait_idle();

        // Start held high: back-to-back sweeps
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        for (int k = 0; k < 3; k++) begin
            e.tbl      = 8'hAB;
            e.done_cyc = t + k * PERIOD + 8 * H;
            sb.push_back(e);
        end
        sw_T      = t;
        sw_active = 1'b1;
        while (cyc < t + 2 * PERIOD + 8 * H) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Glitching gate output, correct only where it is sampled
        mode = 2;
        start_sweep(8'hAB, t);
        wait_idle();
        mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
